// File: rtl/twos_cla_pkg.sv
// Shared mode codes and FSM state encoding for the sequential two's-complement unit.
package twos_cla_pkg;
  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_INC  = 2'b01;
  localparam logic [1:0] MODE_NEG  = 2'b10;
  localparam logic [1:0] MODE_ABS  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/twos_cla_slice.sv
// Combinational CHUNK-bit lookahead incrementer: each carry is CIN ANDed with all lower bits.
module twos_cla_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_cin,
  output logic [CHUNK-1:0] o_s,
  output logic             o_cout
);
  logic [CHUNK:0] w_c;

  always_comb begin
    w_c[0] = i_cin;
    for (int i = 1; i <= CHUNK; i++) w_c[i] = w_c[i-1] & i_b[i-1];
  end

  assign o_s    = i_b ^ w_c[CHUNK-1:0];
  assign o_cout = w_c[CHUNK];
endmodule

// File: rtl/twos_cla_seq.sv
// Multi-cycle PASS/INC/NEG/ABS unit: one incrementer slice per cycle, LSB first,
// finishing as soon as the carry dies.
module twos_cla_seq
  import twos_cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);
  localparam int NSLICE = WIDTH / CHUNK;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_res, r_data;
  logic [IW-1:0]    r_idx;
  logic             r_carry, r_bmsb, r_cout, r_ovf;
  logic [1:0]       r_mode;

  logic             w_neg, w_cin, w_cout, w_last, w_stop, w_msb, w_ovf;
  logic [WIDTH-1:0] w_opnd, w_res_nx;
  logic [CHUNK-1:0] w_b, w_s;

  assign w_neg  = (in_mode == MODE_NEG) || ((in_mode == MODE_ABS) && in_data[WIDTH-1]);
  assign w_cin  = (in_mode == MODE_INC) || w_neg;
  assign w_opnd = w_neg ? ~in_data : in_data;

  assign w_b = r_res[r_idx*CHUNK +: CHUNK];

  twos_cla_slice #(.CHUNK(CHUNK)) u_slice (
    .i_b    (w_b),
    .i_cin  (r_carry),
    .o_s    (w_s),
    .o_cout (w_cout)
  );

  always_comb begin
    w_res_nx = r_res;
    w_res_nx[r_idx*CHUNK +: CHUNK] = w_s;
  end

  assign w_last = (r_idx == LAST);
  assign w_stop = !w_cout || w_last;
  assign w_msb  = w_res_nx[WIDTH-1];
  // Only INC, NEG and negative ABS ever reach RUN; the latter two overflow on the most-negative input.
  assign w_ovf  = (r_mode == MODE_INC) ? (~r_bmsb & w_msb) : (r_bmsb & w_msb);

  assign in_ready  = rst_n && (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state != ST_IDLE);
  assign out_data  = r_data;
  assign out_cout  = r_cout;
  assign out_ovf   = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_res   <= '0;
      r_data  <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_bmsb  <= 1'b0;
      r_mode  <= MODE_PASS;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) begin
          r_res   <= w_opnd;
          r_idx   <= '0;
          r_carry <= w_cin;
          r_bmsb  <= in_data[WIDTH-1];
          r_mode  <= in_mode;
          if (!w_cin) begin
            r_data  <= w_opnd;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_res   <= w_res_nx;
          r_carry <= w_cout;
          r_idx   <= r_idx + 1'b1;
          if (w_stop) begin
            r_data  <= w_res_nx;
            r_cout  <= w_cout & w_last;
            r_ovf   <= w_ovf;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: if (out_ready) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_twos_cla_seq.sv
// Bench for twos_cla_seq: directed 32/4 vectors with a queue-based monitor, plus an
// exhaustive 8/2 sweep with random backpressure.
module tb_twos_cla_seq;
  import twos_cla_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv, ir, ovl, ordy, oc, oo, bsy;
  logic [31:0] id, od;
  logic [1:0]  im;

  logic        s_iv, s_ir, s_ovl, s_ordy, s_oc, s_oo, s_bsy;
  logic [7:0]  s_id, s_od;
  logic [1:0]  s_im;

  twos_cla_seq #(.WIDTH(32), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .in_data(id), .in_mode(im),
    .out_valid(ovl), .out_ready(ordy), .out_data(od), .out_cout(oc), .out_ovf(oo), .busy(bsy)
  );

  twos_cla_seq #(.WIDTH(8), .CHUNK(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(s_iv), .in_ready(s_ir), .in_data(s_id), .in_mode(s_im),
    .out_valid(s_ovl), .out_ready(s_ordy), .out_data(s_od), .out_cout(s_oc), .out_ovf(s_oo),
    .busy(s_bsy)
  );

  typedef struct {
    logic [31:0] d;
    logic        c;
    logic        o;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: plain modular arithmetic; k = slices visited = trailing ones of the
  // incremented operand / CHUNK + 1, capped at the slice count.
  function automatic void model(input int w, input int ch, input logic [1:0] m, input logic [31:0] b,
                                output logic [31:0] r, output logic co, output logic ov,
                                output int k);
    logic [63:0] msk, bb, opnd, res;
    logic        neg, cin;
    int          t;
    msk  = (64'd1 << w) - 64'd1;
    bb   = {32'd0, b} & msk;
    neg  = (m == MODE_NEG) || ((m == MODE_ABS) && bb[w-1]);
    cin  = (m == MODE_INC) || neg;
    if (m == MODE_INC) res = (bb + 64'd1) & msk;
    else if (neg)      res = (~bb + 64'd1) & msk;
    else               res = bb;
    opnd = neg ? (~bb & msk) : bb;
    t = 0;
    while (t < w && opnd[t]) t++;
    k  = !cin ? 0 : ((t / ch + 1 > w / ch) ? w / ch : t / ch + 1);
    r  = res[31:0];
    co = cin && (t == w);
    ov = ((m == MODE_INC) && (bb == (msk >> 1))) || (neg && (bb == (64'd1 << (w - 1))));
  endfunction

  // Whenever a result is presented it must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && ovl) begin
      if (exp_q.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
      else begin
        chk("mon_data", od, exp_q[0].d);
        chk("mon_cout", {31'd0, oc}, {31'd0, exp_q[0].c});
        chk("mon_ovf",  {31'd0, oo}, {31'd0, exp_q[0].o});
      end
    end
  end

  task automatic op32(input logic [1:0] m, input logic [31:0] b, input int hold,
                      output logic [31:0] d, output logic c, output logic o, output int lat);
    logic [31:0] er;
    logic        ec, eo;
    int          ek, n;
    model(32, 4, m, b, er, ec, eo, ek);
    n = 0;
    while (!ir && n < 50) begin @(posedge clk); #1; n++; end
    if (!ir) chk("ready_timeout", 32'd0, 32'd1);
    exp_q.push_back('{d: er, c: ec, o: eo});
    iv = 1'b1; id = b; im = m;
    @(posedge clk); #1;
    iv = 1'b0; id = $urandom; im = 2'($urandom);
    lat = 0;
    while (!ovl && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("latency", lat, ek);
    d = od; c = oc; o = oo;
    for (int h = 0; h < hold; h++) begin
      chk("ready_in_done", {31'd0, ir}, 32'd0);
      iv = 1'b1; id = $urandom; im = 2'($urandom);
      @(posedge clk); #1;
    end
    iv = 1'b0;
    ordy = 1'b1;
    @(posedge clk); #1;
    ordy = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    chk("drop_valid", {31'd0, ovl}, 32'd0);
    chk("idle_busy",  {31'd0, bsy}, 32'd0);
    chk("idle_ready", {31'd0, ir},  32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, er;
    logic        c, o, ec, eo;
    int          lat, ek, n, stall;

    iv = 0; id = 0; im = 0; ordy = 0;
    s_iv = 0; s_id = 0; s_im = 0; s_ordy = 0;

    #12;
    chk("rst_valid", {31'd0, ovl}, 32'd0);
    chk("rst_data",  od, 32'd0);
    chk("rst_flags", {30'd0, oc, oo}, 32'd0);
    chk("rst_busy",  {31'd0, bsy}, 32'd0);
    chk("rst_ready", {31'd0, ir}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    model(32, 4, MODE_NEG, 32'h0, er, ec, eo, ek);
    chk("model_neg0_data", er, 32'h0);
    chk("model_neg0_k", ek, 32'd8);
    model(32, 4, MODE_INC, 32'h7FFF_FFFF, er, ec, eo, ek);
    chk("model_incmax", {er[31:28], 26'd0, ec, eo}, {4'h8, 26'd0, 1'b0, 1'b1});

    op32(MODE_INC, 32'h0, 0, d, c, o, lat);
    chk("inc0_data", d, 32'h1); chk("inc0_flags", {30'd0, c, o}, 32'd0); chk("inc0_lat", lat, 32'd1);
    op32(MODE_NEG, 32'h1, 0, d, c, o, lat);
    chk("neg1_data", d, 32'hFFFF_FFFF); chk("neg1_lat", lat, 32'd1);
    op32(MODE_NEG, 32'h0, 0, d, c, o, lat);
    chk("neg0_data", d, 32'h0); chk("neg0_flags", {30'd0, c, o}, 32'd2); chk("neg0_lat", lat, 32'd8);
    op32(MODE_INC, 32'h7FFF_FFFF, 0, d, c, o, lat);
    chk("incmax_data", d, 32'h8000_0000); chk("incmax_flags", {30'd0, c, o}, 32'd1);
    chk("incmax_lat", lat, 32'd8);
    op32(MODE_ABS, 32'h8000_0000, 0, d, c, o, lat);
    chk("absmin_data", d, 32'h8000_0000); chk("absmin_ovf", {31'd0, o}, 32'd1);
    op32(MODE_ABS, 32'hFFFF_FFFB, 0, d, c, o, lat);
    chk("absm5_data", d, 32'h5); chk("absm5_flags", {30'd0, c, o}, 32'd0);
    op32(MODE_PASS, 32'h1234_5678, 0, d, c, o, lat);
    chk("pass_data", d, 32'h1234_5678); chk("pass_lat", lat, 32'd0);
    op32(MODE_ABS, 32'h5, 0, d, c, o, lat);
    chk("abs5_data", d, 32'h5); chk("abs5_lat", lat, 32'd0); chk("abs5_flags", {30'd0, c, o}, 32'd0);

    // Backpressure: result held 10 cycles while in_valid pulses are offered.
    op32(MODE_INC, 32'h0000_000F, 10, d, c, o, lat);
    chk("hold_data", d, 32'h10); chk("hold_lat", lat, 32'd2);
    op32(MODE_NEG, 32'h2, 0, d, c, o, lat);
    chk("after_hold_data", d, 32'hFFFF_FFFE);

    // Abort in RUN at idx=3.
    iv = 1'b1; id = 32'hFFFF_FFFF; im = MODE_INC;
    @(posedge clk); #1;
    iv = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("abort_busy", {31'd0, bsy}, 32'd1);
    chk("abort_novalid", {31'd0, ovl}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_rst_outs", {od[0], od[31], 27'd0, ovl, oc, oo}, 32'd0);
    chk("abort_rst_data", od, 32'd0);
    chk("abort_rst_ctl", {30'd0, bsy, ir}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    repeat (12) begin @(posedge clk); #1; if (ovl) n++; end
    chk("abort_no_result", n, 32'd0);
    op32(MODE_INC, 32'h0000_00FF, 0, d, c, o, lat);
    chk("post_rst_data", d, 32'h100); chk("post_rst_lat", lat, 32'd3);

    // Exhaustive 8-bit, 2-bit-slice sweep.
    for (int m = 0; m < 4; m++) begin
      for (int b = 0; b < 256; b++) begin
        model(8, 2, m[1:0], b, er, ec, eo, ek);
        n = 0;
        while (!s_ir && n < 20) begin @(posedge clk); #1; n++; end
        if (!s_ir) chk("x_ready_timeout", 32'd0, 32'd1);
        s_iv = 1'b1; s_id = b[7:0]; s_im = m[1:0];
        @(posedge clk); #1;
        s_iv = 1'b0;
        n = 0;
        while (!s_ovl && n < 10) begin @(posedge clk); #1; n++; end
        chk("x_lat", n, ek);
        chk("x_data", {24'd0, s_od}, er);
        chk("x_flags", {30'd0, s_oc, s_oo}, {30'd0, ec, eo});
        stall = $urandom_range(0, 2);
        repeat (stall) begin
          @(posedge clk); #1;
          chk("x_hold", {23'd0, s_ovl, s_od}, {23'd0, 1'b1, er[7:0]});
        end
        s_ordy = 1'b1;
        @(posedge clk); #1;
        s_ordy = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
